// File: rtl/ff_excitation_gen.sv
// ff_excitation_gen: derives SR/JK/T/D excitation for a target Q sequence and self-checks four flip-flop models
module ff_excitation_gen #(
  parameter int WIDTH  = 8,
  parameter bit INIT_Q = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         pattern,
  input  logic                     flt_inj,
  output logic                     S,
  output logic                     R,
  output logic                     J,
  output logic                     K,
  output logic                     T,
  output logic                     D,
  output logic                     Q_sr,
  output logic                     Q_jk,
  output logic                     Q_t,
  output logic                     Q_d,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     done,
  output logic                     mismatch
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] pat;
  logic q_ref, tgt, last, nx_sr, nx_jk, nx_t, nx_d;
  // state register; reset aborts any run without a done pulse
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nx;
  // next state: accept in IDLE, walk the pattern in RUN, one DONE cycle
  always_comb begin
    last = bit_idx == IW'(WIDTH - 1);
    state_nx = state == IDLE ? (load_valid ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  // outputs: excitation from the reference state, zero outside RUN; hold resolves to 0
  always_comb begin
    busy = state == RUN;
    load_ready = state == IDLE;
    done = state == DONE;
    tgt = pat[bit_idx];
    S = busy & tgt & ~q_ref;
    R = busy & ~tgt & q_ref;
    J = S;
    K = R;
    T = busy & (tgt ^ q_ref);
    D = busy & tgt;
  end
  // characteristic equations of the models; the T model sees the injected fault
  always_comb begin
    nx_sr = S | (~R & Q_sr);
    nx_jk = (J & ~Q_jk) | (~K & Q_jk);
    nx_t = Q_t ^ T ^ flt_inj;
    nx_d = D;
  end
  // datapath: pattern capture, model update, bit walk and sticky mismatch
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat <= '0;
      bit_idx <= '0;
      mismatch <= 1'b0;
      q_ref <= INIT_Q;
      Q_sr <= INIT_Q;
      Q_jk <= INIT_Q;
      Q_t <= INIT_Q;
      Q_d <= INIT_Q;
    end else if (state == IDLE && load_valid) begin
      pat <= pattern;
      bit_idx <= '0;
      mismatch <= 1'b0;
    end else if (state == RUN) begin
      Q_sr <= nx_sr;
      Q_jk <= nx_jk;
      Q_t <= nx_t;
      Q_d <= nx_d;
      q_ref <= tgt;
      bit_idx <= last ? '0 : bit_idx + IW'(1);
      mismatch <= mismatch | (nx_sr != tgt) | (nx_jk != tgt) | (nx_t != tgt) | (nx_d != tgt);
    end
  end
endmodule

// File: tb/tb_ff_excitation_gen.sv
// tb_ff_excitation_gen: directed and randomized checks against a flip-flop behaviour model
module tb_ff_excitation_gen;
  logic clk = 0, reset = 0, load_valid = 0, flt_inj = 0;
  logic [7:0] pattern = '0;
  logic load_ready, S, R, J, K, T, D, Q_sr, Q_jk, Q_t, Q_d, busy, done, mismatch;
  logic [2:0] bit_idx;
  int checks = 0, errors = 0;
  logic qref = 0, mm = 0;
  logic mq [4] = '{0, 0, 0, 0};

  ff_excitation_gen #(.WIDTH(8), .INIT_Q(1'b0)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .pattern(pattern), .flt_inj(flt_inj), .S(S), .R(R), .J(J), .K(K), .T(T), .D(D),
    .Q_sr(Q_sr), .Q_jk(Q_jk), .Q_t(Q_t), .Q_d(Q_d), .busy(busy), .bit_idx(bit_idx),
    .done(done), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_models();
    chk("Q_sr", Q_sr, mq[0]);
    chk("Q_jk", Q_jk, mq[1]);
    chk("Q_t", Q_t, mq[2]);
    chk("Q_d", Q_d, mq[3]);
  endtask

  task automatic chk_quiet(input string where);
    chk({where, "_S"}, S, 0);
    chk({where, "_R"}, R, 0);
    chk({where, "_J"}, J, 0);
    chk({where, "_K"}, K, 0);
    chk({where, "_T"}, T, 0);
    chk({where, "_D"}, D, 0);
  endtask

  // fb: bit with fault injected, ab: bit during which reset is asserted,
  // pb: bit during which a spurious offer is made, dpoke: offer during DONE
  task automatic run_pat(input logic [7:0] p, input int fb, input int ab, input int pb, input bit dpoke);
    logic tg, es, er, et, ti;
    chk("ready_before", load_ready, 1);
    load_valid = 1;
    pattern = p;
    step();
    mm = 0;
    for (int i = 0; i < 8; i++) begin
      load_valid = (i == pb);
      pattern = (i == pb) ? ~p : p;
      flt_inj = (i == fb);
      tg = p[i];
      es = (tg == 1 && qref == 0);
      er = (tg == 0 && qref == 1);
      et = (tg != qref);
      chk("busy", busy, 1);
      chk("ready_run", load_ready, 0);
      chk("bit_idx", bit_idx, i);
      chk("S", S, es);
      chk("R", R, er);
      chk("J", J, es);
      chk("K", K, er);
      chk("T", T, et);
      chk("D", D, tg);
      chk("mismatch_run", mismatch, mm);
      chk_models();
      if (i == ab) begin
        reset = 0;
        step();
        reset = 1;
        load_valid = 0;
        flt_inj = 0;
        qref = 0;
        mm = 0;
        mq = '{0, 0, 0, 0};
        chk("abort_ready", load_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_idx", bit_idx, 0);
        chk("abort_mm", mismatch, 0);
        chk_models();
        step();
        chk("abort_nodone", done, 0);
        chk("abort_idle", load_ready, 1);
        return;
      end
      if (es) mq[0] = 1;
      else if (er) mq[0] = 0;
      if (es && er) mq[1] = ~mq[1];
      else if (es) mq[1] = 1;
      else if (er) mq[1] = 0;
      ti = et ^ (i == fb);
      if (ti) mq[2] = ~mq[2];
      mq[3] = tg;
      qref = tg;
      for (int m = 0; m < 4; m++) if (mq[m] != tg) mm = 1;
      step();
    end
    load_valid = dpoke;
    pattern = ~p;
    flt_inj = 0;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_ready", load_ready, 0);
    chk("done_idx", bit_idx, 0);
    chk("done_mm", mismatch, mm);
    chk_quiet("done");
    chk_models();
    step();
    load_valid = 0;
    chk("idle_done", done, 0);
    chk("idle_ready", load_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_idx", bit_idx, 0);
    chk("idle_mm", mismatch, mm);
    chk_quiet("idle");
  endtask

  initial begin
    logic [7:0] p;
    int fb, ab, pb;
    reset = 0;
    step();
    step();
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mm", mismatch, 0);
    chk("rst_idx", bit_idx, 0);
    chk_quiet("rst");
    chk_models();
    reset = 1;
    step();
    run_pat(8'b1011_0010, -1, -1, 3, 1'b1);
    chk("b2_mm_clear", mismatch, 0);
    run_pat(8'hFF, -1, -1, -1, 1'b0);
    chk("ff_qsr", Q_sr, 1);
    chk("ff_qt", Q_t, 1);
    run_pat(8'h0F, 2, -1, -1, 1'b0);
    chk("flt_mm", mismatch, 1);
    run_pat(8'h00, -1, -1, -1, 1'b0);
    run_pat(8'hAA, -1, 3, -1, 1'b0);
    for (int n = 0; n < 24; n++) begin
      p = 8'($urandom);
      fb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      pb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_pat(p, fb, ab, pb, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("gap_ready", load_ready, 1);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
